// File: rtl/demux1_16_deser.sv
// demux1_16_deser: 1-to-16 sequential serial-to-parallel demultiplexer.
// Each accepted din bit is steered into shadow[sel] and sel advances. When the
// frame is complete it is published on out/out_valid and held until out_ack.
// Build option: define DEMUX_PARITY_EN to add a 17th even-parity transfer,
// a PARITY state and the perr output. Without it a frame is 16 transfers.
module demux1_16_deser (
  input  logic        clk,
  input  logic        rst,
  input  logic        din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic [3:0]  sel,
  output logic [15:0] out,
  output logic        out_valid,
`ifdef DEMUX_PARITY_EN
  output logic        perr,
`endif
  input  logic        out_ack
);

`ifdef DEMUX_PARITY_EN
  // Bit 15 is kept in the shadow because the frame is only published after
  // the parity transfer.
  localparam int SHADOW_W = 16;
`else
  // Bit 15 goes straight from din into out, so the shadow only needs 15 bits.
  localparam int SHADOW_W = 15;
`endif

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
`ifdef DEMUX_PARITY_EN
    ST_PARITY  = 2'd1,
`endif
    ST_FULL    = 2'd2
  } state_t;

`ifdef DEMUX_PARITY_EN
  // Even parity check: result is 1 when data plus parity bit has odd weight.
  function automatic logic f_parity_err(input logic [15:0] data, input logic pbit);
    return (^data) ^ pbit;
  endfunction
`endif

  state_t                r_state;
  logic [3:0]            r_sel;
  logic [SHADOW_W-1:0]   r_shadow;
  logic [15:0]           r_out;
  logic                  r_out_valid;
  logic                  r_ready;
`ifdef DEMUX_PARITY_EN
  logic                  r_perr;
`endif
  logic                  w_xfer;

  // Ready is a registered state flag, gated low while reset is held.
  assign din_ready = r_ready & ~rst;
  assign w_xfer    = din_valid & din_ready;
  assign sel       = r_sel;
  assign out       = r_out;
  assign out_valid = r_out_valid;
`ifdef DEMUX_PARITY_EN
  assign perr      = r_perr;
`endif

  // Frame collection FSM: steers bits into the shadow, publishes and holds frames.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_COLLECT;
      r_sel       <= 4'd0;
      r_shadow    <= '0;
      r_out       <= 16'h0000;
      r_out_valid <= 1'b0;
      r_ready     <= 1'b1;
`ifdef DEMUX_PARITY_EN
      r_perr      <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (w_xfer) begin
            // Decoded write keeps the index inside the shadow width.
            for (int i = 0; i < SHADOW_W; i++) begin
              if (r_sel == 4'(i)) begin
                r_shadow[i] <= din;
              end
            end
            if (r_sel != 4'd15) begin
              r_sel <= r_sel + 4'd1;
            end else begin
`ifdef DEMUX_PARITY_EN
              // sel holds at 15 while the parity bit is awaited.
              r_state <= ST_PARITY;
`else
              r_out       <= {din, r_shadow};
              r_out_valid <= 1'b1;
              r_ready     <= 1'b0;
              r_state     <= ST_FULL;
`endif
            end
          end else begin
            r_state <= ST_COLLECT;
          end
        end
`ifdef DEMUX_PARITY_EN
        ST_PARITY: begin
          if (w_xfer) begin
            r_out       <= r_shadow;
            r_perr      <= f_parity_err(r_shadow, din);
            r_out_valid <= 1'b1;
            r_ready     <= 1'b0;
            r_state     <= ST_FULL;
          end else begin
            r_state <= ST_PARITY;
          end
        end
`endif
        ST_FULL: begin
          // out keeps the frame after the ack; only the valid flag drops.
          if (out_ack) begin
            r_out_valid <= 1'b0;
            r_sel       <= 4'd0;
            r_ready     <= 1'b1;
`ifdef DEMUX_PARITY_EN
            r_perr      <= 1'b0;
`endif
            r_state     <= ST_COLLECT;
          end else begin
            r_state <= ST_FULL;
          end
        end
        default: begin
          // Unreachable encoding: drop any pending frame and restart collection.
          r_state     <= ST_COLLECT;
          r_sel       <= 4'd0;
          r_out_valid <= 1'b0;
          r_ready     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/demux1_16_deser.md
DEMUX1_16_DESER -- requirements
Module: demux1_16_deser

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 din  input  1  serial data bit.
REQ-004 din_valid  input  1  din carries a bit this cycle.
REQ-005 din_ready  output  1  block accepts a bit this cycle; a transfer occurs when din_valid && din_ready.
REQ-006 sel  output  4  index of the output bit the next accepted bit is written to.
REQ-007 out  output  16  last completed frame; bit k = k-th accepted bit of the frame.
REQ-008 out_valid  output  1  out holds an unacknowledged completed frame.
REQ-009 out_ack  input  1  consumer has taken out; honoured only while out_valid=1.
REQ-010 perr  output  1  parity error flag for the current frame; port exists only with DEMUX_PARITY_EN.

Function
REQ-011 The block SHALL be a 1-to-16 sequential demultiplexer: each accepted din bit is steered into shadow bit [sel], and sel then increments.
REQ-012 States SHALL be COLLECT, PARITY (macro builds only) and FULL.
REQ-013 COLLECT: din_ready=1, out_valid=0.
REQ-014 COLLECT, transfer with sel<15: shadow[sel]<=din; sel<=sel+1.
REQ-015 COLLECT, transfer with sel=15, macro absent: out<=shadow with bit15=din; out_valid<=1; next state FULL. Latency is 1 cycle from the final transfer edge to out_valid=1.
REQ-016 COLLECT, transfer with sel=15, macro present: shadow[15]<=din; next state PARITY; sel holds 15.
REQ-017 FULL: din_ready=0, so din_valid is ignored and no bit is lost or written; out and out_valid are held stable until out_ack=1.
REQ-018 FULL with out_ack=1: next cycle out_valid=0, sel=0, state COLLECT; out retains the frame value.
REQ-019 out_ack while out_valid=0 SHALL have no effect.
REQ-020 out SHALL change only at frame completion and never shows partial frames; shadow bits are not cleared between frames.
REQ-021 sel wraps 15->0 only through the FULL->COLLECT transition and never wraps by increment.
REQ-022 din_valid=0 in COLLECT or PARITY SHALL hold all state, so gaps of any length are allowed.

Reset
REQ-023 rst=1 SHALL immediately, without waiting for clk, force state=COLLECT, sel=0, out=16'h0000, shadow=16'h0000, out_valid=0, perr=0.
REQ-024 While rst=1, din_ready SHALL be 0.
REQ-025 If reset is asserted mid-frame or in FULL, the partial or pending frame SHALL be discarded and collection restarts at sel=0 on the first edge after release.

Configuration
REQ-026 Macro DEMUX_PARITY_EN SHALL select the parity build.
REQ-027 With DEMUX_PARITY_EN defined:
- a frame is 17 transfers; the 17th is an even-parity bit accepted in PARITY (din_ready=1).
- on that transfer, out<=shadow, perr<=^shadow^din, out_valid<=1, state FULL.
- perr is held with out and cleared on the ack transition.
REQ-028 Without DEMUX_PARITY_EN, a frame is 16 transfers, there is no PARITY state, and there is no perr port.

Verification
REQ-029 Reset: assert rst mid-cycle -> out=0, out_valid=0, sel=0, din_ready=0 before the next clk edge.
REQ-030 Frame: stream 16'b1111_0101_0001_1000 LSB first, back-to-back, then hold out_ack=0:
- out_valid rises 1 cycle after the 16th transfer;
- out=16'hF518 and is held;
- din_ready=0 while held.
REQ-031 Gaps: same frame with din_valid low for 3 cycles between each bit -> identical out; sel steps 0..15.
REQ-032 Ack and back-pressure: pulse out_ack for 1 cycle -> next cycle out_valid=0, sel=0, din_ready=1. Drive din_valid=1 during FULL -> the next frame is unaffected.
REQ-033 Reset mid-frame: reset after 7 bits, then send a full 16'hA5C3 frame -> out=16'hA5C3 with no residue.
REQ-034 Parity (DEMUX_PARITY_EN): frame 16'hF518 (eight ones) plus parity bit 0 -> perr=0; the same frame with parity bit 1 -> perr=1.
